// File: rtl/divn_pulse_checker.sv
// Receive-side monitor for a divide-by-N strobe: checks one-clock-wide pulses
// every N clocks and reports lock, per-error pulses and a saturating error count.
module divn_pulse_checker #(
    parameter int N        = 3,
    parameter int LOCK_CNT = 4,
    parameter int PW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          y,
    output logic          locked,
    output logic          err,
    output logic [7:0]    err_count,
    output logic [PW-1:0] last_period,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam logic [PW-1:0] N_P     = PW'(N);
    localparam logic [PW-1:0] ONE_P   = PW'(1);
    localparam logic [PW-1:0] CNT_MAX = '1;
    localparam logic [8:0]    LOCK_P  = 9'(LOCK_CNT);

    state_e        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [7:0]    good_q, good_d;
    logic          locked_q, locked_d;
    logic          err_q, err_d;
    logic [7:0]    err_count_q, err_count_d;
    logic [PW-1:0] last_period_q, last_period_d;
    logic [8:0]    good_inc;

    assign good_inc = {1'b0, good_q} + 9'd1;

    // Period counter: restarts at 1 on a sampled pulse, otherwise counts up and sticks at max.
    always_comb begin
        cnt_d = cnt_q;
        if (y) begin
            cnt_d = ONE_P;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + ONE_P;
        end
    end

    always_comb begin
        state_d       = state_q;
        good_d        = good_q;
        err_d         = 1'b0;
        last_period_d = last_period_q;
        case (state_q)
            IDLE: begin
                if (y) begin
                    state_d = ACQ;
                    good_d  = 8'd0;
                end
            end
            ACQ, LOCKED: begin
                if (y) begin
                    last_period_d = cnt_q;
                    if (cnt_q == N_P) begin
                        if (state_q == ACQ) begin
                            good_d = good_inc[7:0];
                            if (good_inc == LOCK_P) begin
                                state_d = LOCKED;
                            end
                        end
                    end else begin
                        // Early or wide pulse: it becomes the new reference.
                        err_d   = 1'b1;
                        state_d = ACQ;
                        good_d  = 8'd0;
                    end
                end else if (cnt_q == N_P) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    good_d  = 8'd0;
                end
            end
            default: begin
                state_d = IDLE;
                good_d  = 8'd0;
            end
        endcase
        locked_d    = (state_d == LOCKED);
        err_count_d = err_count_q;
        if (err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            good_q        <= 8'd0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            err_count_q   <= 8'd0;
            last_period_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            good_q        <= good_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
            err_count_q   <= err_count_d;
            last_period_q <= last_period_d;
        end
    end

    assign locked      = locked_q;
    assign err         = err_q;
    assign err_count   = err_count_q;
    assign last_period = last_period_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_divn_pulse_checker.sv
// Randomized bench for divn_pulse_checker against a pulse-timing reference model,
// finishing with a divide-by-3 Moore source driving the checker.
module tb_divn_pulse_checker;

    localparam int N        = 3;
    localparam int LOCK_CNT = 4;
    localparam int PW       = 8;
    localparam int CNT_SAT  = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          y_drv = 1'b0;
    logic          use_div = 1'b0;
    logic          y_dut;
    logic          locked;
    logic          err;
    logic [7:0]    err_count;
    logic [PW-1:0] last_period;
    logic [1:0]    state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // Clock / reset block
    always #5 clk = ~clk;

    // Divide-by-3 Moore source with active-high reset taken from the bench reset.
    logic       div_rst;
    logic [1:0] div_s;
    logic       div3_y;
    assign div_rst = ~reset;
    always_ff @(posedge clk or posedge div_rst) begin
        if (div_rst) div_s <= 2'd0;
        else         div_s <= (div_s == 2'd2) ? 2'd0 : div_s + 2'd1;
    end
    assign div3_y = (div_s == 2'd0);
    assign y_dut  = use_div ? div3_y : y_drv;

    divn_pulse_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .PW(PW)) dut (
        .clk         (clk),
        .reset       (reset),
        .y           (y_dut),
        .locked      (locked),
        .err         (err),
        .err_count   (err_count),
        .last_period (last_period),
        .state_dbg   (state_dbg)
    );

    // Reference model: pulse timing in absolute edge numbers.
    int edge_n    = 0;
    int last_y    = 0;
    int run       = 0;
    bit have_ref  = 0;
    int exp_err   = 0;
    int exp_cnt   = 0;
    int exp_last  = 0;
    int exp_lock  = 0;
    int exp_state = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
        end
    endtask

    task automatic model_reset();
        have_ref = 0;
        run      = 0;
        exp_err  = 0;
        exp_cnt  = 0;
        exp_last = 0;
        exp_lock = 0;
        exp_state = 0;
        last_y   = edge_n;
    endtask

    task automatic model_edge(input logic yv);
        int since;
        since = edge_n - last_y;
        if (since > CNT_SAT) since = CNT_SAT;
        exp_err = 0;
        if (yv) begin
            if (!have_ref) begin
                have_ref = 1;
                run      = 0;
            end else begin
                exp_last = since;
                if (since == N) run++;
                else begin
                    exp_err = 1;
                    run     = 0;
                end
            end
            last_y = edge_n;
        end else if (have_ref && since == N) begin
            exp_err  = 1;
            have_ref = 0;
            run      = 0;
        end
        if (exp_err == 1 && exp_cnt < 255) exp_cnt++;
        exp_lock  = (have_ref && run >= LOCK_CNT) ? 1 : 0;
        exp_state = !have_ref ? 0 : (exp_lock == 1 ? 2 : 1);
        edge_n++;
    endtask

    task automatic check_outputs();
        check("err", err, exp_err);
        check("locked", locked, exp_lock);
        check("err_count", err_count, exp_cnt);
        check("last_period", last_period, exp_last);
        check("state", state_dbg, exp_state);
    endtask

    // Driver tasks
    task automatic step(input logic yv);
        y_drv = yv;
        @(posedge clk);
        model_edge(yv);
        #1;
        check_outputs();
    endtask

    task automatic step_div();
        logic yv;
        yv = y_dut;
        @(posedge clk);
        model_edge(yv);
        #1;
        check_outputs();
    endtask

    task automatic pulse(input int p);
        step(1'b1);
        for (int i = 1; i < p; i++) step(1'b0);
    endtask

    initial begin
        int r;
        int p;
        reset = 1'b0;
        #23;
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_last_period", last_period, 0);
        check("rst_state", state_dbg, 0);
        @(negedge clk);
        model_reset();
        reset = 1'b1;

        // Ideal train then a missing pulse, an early pulse and a wide pulse.
        repeat (6) pulse(3);
        check("t1_locked", locked, 1);
        repeat (6) step(1'b0);
        repeat (6) pulse(3);
        pulse(2);
        repeat (6) pulse(3);
        step(1'b1);
        step(1'b1);
        check("t4_last_period", last_period, 1);
        repeat (6) pulse(3);

        // Random mix biased towards good periods.
        repeat (300) begin
            r = $urandom_range(0, 9);
            if (r < 6)      p = 3;
            else if (r < 8) p = $urandom_range(1, 2);
            else            p = $urandom_range(4, 6);
            pulse(p);
        end

        // Error-count saturation.
        repeat (300) pulse(2);
        check("t5_err_count_sat", err_count, 255);

        // Async reset mid-lock, then the divide-by-3 source.
        repeat (6) pulse(3);
        step(1'b1);
        check("t6_pre_locked", locked, 1);
        step(1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_locked", locked, 0);
        check("t6_async_err", err, 0);
        check("t6_async_err_count", err_count, 0);
        check("t6_async_last_period", last_period, 0);
        model_reset();
        use_div = 1'b1;
        #3;
        reset = 1'b1;
        repeat (100) step_div();
        check("t6_div3_locked", locked, 1);
        check("t6_div3_err_count", err_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
